// File: rtl/zap_mem_arbiter.sv
// Memory bus arbiter between fetch and memory stages, with flush drain.
// Optional round-robin priority when ZAP_ARB_ROUND_ROBIN_EN is defined.
module zap_mem_arbiter #(
  parameter int PHY_REGS = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_d_load,
  input  logic        i_d_store,
  input  logic [31:0] i_d_address,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_be,
  output logic [31:0] o_d_rdata,
  output logic        o_d_abort,
  output logic        o_data_stall,
  input  logic        i_i_req,
  input  logic [31:0] i_i_address,
  output logic [31:0] o_i_rdata,
  output logic        o_i_abort,
  output logic        o_instr_stall,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    DGNT,
    IGNT,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        d_pend;
  logic        pick_d;
  logic        d_ack;
  logic        i_ack;
  logic        unused_phy;

  assign unused_phy = |PHY_REGS;
  assign d_pend     = i_d_load | i_d_store;

`ifdef ZAP_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  // On contention the side that did not win last time goes first.
  assign pick_d = d_pend & ~(i_i_req & last_d_q);
`else
  assign pick_d = d_pend;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
`ifdef ZAP_ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = DGNT;
          req_d   = 1'b1;
          we_d    = i_d_store;
          addr_d  = i_d_address;
          wdata_d = i_d_wdata;
          be_d    = i_d_be;
`ifdef ZAP_ARB_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`endif
        end else if (i_i_req) begin
          state_d = IGNT;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = i_i_address;
          wdata_d = 32'h0;
          be_d    = 4'hF;
`ifdef ZAP_ARB_ROUND_ROBIN_EN
          last_d_d = 1'b0;
`endif
        end
      end
      DGNT, IGNT: begin
        if (i_bus_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (i_clear_from_writeback) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The bus cannot be abandoned; wait out the ack and drop it.
        if (i_bus_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

`ifdef ZAP_ARB_ROUND_ROBIN_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) last_d_q <= 1'b0;
    else         last_d_q <= last_d_d;
  end
`endif

  // An ack coinciding with a flush is discarded like a drained one.
  assign d_ack = (state_q == DGNT) & i_bus_ack & ~i_clear_from_writeback;
  assign i_ack = (state_q == IGNT) & i_bus_ack & ~i_clear_from_writeback;

  assign o_d_rdata     = i_bus_rdata;
  assign o_i_rdata     = i_bus_rdata;
  assign o_d_abort     = d_ack & i_bus_err;
  assign o_i_abort     = i_ack & i_bus_err;
  assign o_data_stall  = d_pend & ~d_ack;
  assign o_instr_stall = (i_i_req & ~i_ack) | d_pend;

  assign o_bus_req   = req_q;
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;
  assign o_bus_be    = be_q;

endmodule
